// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data-memory port between the CPU pipeline (priority) and a loader/debug master
module dmem_arbiter #(
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_cpu_re,
    input  logic        i_cpu_we,
    input  logic [31:0] i_cpu_addr,
    input  logic [31:0] i_cpu_wdata,
    input  logic [1:0]  i_cpu_size,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_stall,
    input  logic        i_ld_req,
    input  logic        i_ld_we,
    input  logic [31:0] i_ld_addr,
    input  logic [31:0] i_ld_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_lock,
    output logic        o_ld_gnt,
    output logic [31:0] o_ld_rdata,
    output logic        o_ld_rvalid,
    output logic        o_mem_re,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic [1:0]  o_mem_size,
    input  logic [31:0] i_mem_rdata
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [WW-1:0] WAIT_TOP = WW'(MAX_WAIT);
    localparam logic [LW-1:0] LOCK_TOP = LW'(LOCK_MAX);

    typedef enum logic {SHARED, LOCKED} state_t;

    state_t        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [LW-1:0] lock_q, lock_d;
    logic          rel_q, rel_d;
    logic [31:0]   ld_rdata_q, ld_rdata_d;
    logic          ld_rvalid_q, ld_rvalid_d;
    logic          cpu_acc, ld_win, ld_own, ld_gnt, ld_rd;

    // The forced-release flag blocks the starvation override for one cycle after a full-length lock
    assign cpu_acc = i_cpu_re | i_cpu_we;
    assign ld_win  = i_ld_req & (!cpu_acc | ((wait_q == WAIT_TOP) & !rel_q));
    assign ld_own  = i_rst & ((state_q == LOCKED) | ld_win);
    assign ld_gnt  = i_rst & ((state_q == LOCKED) ? i_ld_req : ld_win);
    assign ld_rd   = ld_gnt & !i_ld_we;

    assign o_ld_gnt    = ld_gnt;
    assign o_cpu_stall = ld_own & cpu_acc;
    assign o_cpu_rdata = i_mem_rdata;
    assign o_ld_rdata  = ld_rdata_q;
    assign o_ld_rvalid = ld_rvalid_q;
    assign o_mem_re    = ld_own ? ld_rd : (i_rst & i_cpu_re);
    assign o_mem_we    = ld_own ? (ld_gnt & i_ld_we) : (i_rst & i_cpu_we);
    assign o_mem_addr  = ld_own ? i_ld_addr : i_cpu_addr;
    assign o_mem_wdata = ld_own ? i_ld_wdata : i_cpu_wdata;
    assign o_mem_size  = ld_own ? i_ld_size : i_cpu_size;

    // Next-state: ownership FSM, starvation/lock counters and loader read capture
    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        lock_d      = lock_q;
        rel_d       = 1'b0;
        ld_rvalid_d = ld_rd;
        ld_rdata_d  = ld_rd ? i_mem_rdata : ld_rdata_q;
        if (state_q == LOCKED) begin
            wait_d = '0;
            lock_d = (ld_gnt && lock_q != LOCK_TOP) ? lock_q + 1'b1 : lock_q;
            if (!i_ld_lock || lock_d == LOCK_TOP) begin
                state_d = SHARED;
                rel_d   = (lock_d == LOCK_TOP);
                lock_d  = '0;
            end
        end else if (ld_win) begin
            wait_d = '0;
            if (i_ld_lock) begin
                state_d = (LOCK_MAX > 1) ? LOCKED : SHARED;
                lock_d  = (LOCK_MAX > 1) ? LW'(1) : '0;
                rel_d   = (LOCK_MAX == 1);
            end
        end else if (cpu_acc) begin
            wait_d = (i_ld_req && wait_q != WAIT_TOP) ? wait_q + 1'b1 : wait_q;
        end else if (!i_ld_req) begin
            wait_d = '0;
        end
    end

    // State registers; reset also drops any loader read still in flight
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q     <= SHARED;
            wait_q      <= '0;
            lock_q      <= '0;
            rel_q       <= 1'b0;
            ld_rdata_q  <= '0;
            ld_rvalid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            lock_q      <= lock_d;
            rel_q       <= rel_d;
            ld_rdata_q  <= ld_rdata_d;
            ld_rvalid_q <= ld_rvalid_d;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed checks of dmem_arbiter against a small word memory
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cpu_re, cpu_we, ld_req, ld_we, ld_lock;
    logic [31:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
    logic [1:0]  cpu_size, ld_size;
    logic [31:0] cpu_rdata, ld_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_stall, ld_gnt, ld_rvalid, mem_re, mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem [0:63];
    int          n_run = 0;
    int          n_fail = 0;

    dmem_arbiter #(.MAX_WAIT(8), .LOCK_MAX(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cpu_re(cpu_re), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr),
        .i_cpu_wdata(cpu_wdata), .i_cpu_size(cpu_size),
        .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
        .i_ld_req(ld_req), .i_ld_we(ld_we), .i_ld_addr(ld_addr),
        .i_ld_wdata(ld_wdata), .i_ld_size(ld_size), .i_ld_lock(ld_lock),
        .o_ld_gnt(ld_gnt), .o_ld_rdata(ld_rdata), .o_ld_rvalid(ld_rvalid),
        .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata), .o_mem_size(mem_size), .i_mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    // Word memory standing in for data_mem
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_re = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0; cpu_size = 2'd2;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0; ld_size = 2'd2; ld_lock = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h12345678;
        mem[5] = 32'hCAFEF00D;
        idle();
        cpu_re = 1; ld_req = 1; ld_lock = 1;
        tick(); tick();
        check("rst_gnt", ld_gnt, 0);
        check("rst_stall", cpu_stall, 0);
        check("rst_mem_re", mem_re, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_rvalid", ld_rvalid, 0);
        check("rst_rdata", ld_rdata, 0);
        idle();
        rst = 1;
        // Loader write with the CPU idle, then CPU reads it back
        tick();
        ld_req = 1; ld_we = 1; ld_addr = 32'h40; ld_wdata = 32'hDEADBEEF; ld_size = 2'd2;
        #1;
        check("idle_gnt", ld_gnt, 1);
        check("idle_mem_we", mem_we, 1);
        check("idle_addr", mem_addr, 32'h40);
        check("idle_size", mem_size, 2'd2);
        check("idle_stall", cpu_stall, 0);
        tick();
        idle(); cpu_re = 1; cpu_addr = 32'h40;
        #1;
        check("cpu_rd_data", cpu_rdata, 32'hDEADBEEF);
        check("cpu_rd_stall", cpu_stall, 0);
        check("cpu_rd_re", mem_re, 1);
        // Starvation bound: loader forced through in the 9th busy cycle
        tick();
        idle(); cpu_re = 1; ld_req = 1; ld_addr = 32'h10;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) tick();
            #1;
            check($sformatf("starve_gnt%0d", k), ld_gnt, k == 9);
            check($sformatf("starve_stall%0d", k), cpu_stall, k == 9);
        end
        tick();
        idle(); cpu_re = 1;
        #1;
        check("starve_rvalid", ld_rvalid, 1);
        check("starve_rdata", ld_rdata, 32'h12345678);
        check("starve_after_stall", cpu_stall, 0);
        check("starve_after_gnt", ld_gnt, 0);
        tick();
        idle();
        #1;
        check("starve_rvalid_end", ld_rvalid, 0);
        // Back-to-back loader reads
        tick();
        ld_req = 1; ld_addr = 32'h10;
        #1;
        check("b2b_gnt0", ld_gnt, 1);
        tick();
        ld_addr = 32'h14;
        #1;
        check("b2b_gnt1", ld_gnt, 1);
        check("b2b_rvalid0", ld_rvalid, 1);
        check("b2b_rdata0", ld_rdata, 32'h12345678);
        tick();
        idle();
        #1;
        check("b2b_rvalid1", ld_rvalid, 1);
        check("b2b_rdata1", ld_rdata, 32'hCAFEF00D);
        tick();
        #1;
        check("b2b_rvalid_end", ld_rvalid, 0);
        // Lock burst: 16 grants, one CPU slot, then the loader relocks
        tick();
        cpu_addr = 32'h40; ld_req = 1; ld_we = 1; ld_lock = 1;
        for (int c = 0; c <= 17; c++) begin
            if (c > 0) tick();
            cpu_re = (c != 0 && c != 17);
            ld_addr = 32'h80 + 32'(4 * c);
            ld_wdata = 32'(c);
            #1;
            check($sformatf("lock_gnt%0d", c), ld_gnt, c != 16);
            check($sformatf("lock_stall%0d", c), cpu_stall, c >= 1 && c <= 15);
            check($sformatf("lock_mem_re%0d", c), mem_re, c == 16);
        end
        tick();
        ld_lock = 0; cpu_re = 1;
        #1;
        check("unlock_gnt", ld_gnt, 1);
        check("unlock_stall", cpu_stall, 1);
        tick();
        idle(); cpu_re = 1; cpu_addr = 32'h8C;
        #1;
        check("unlock_cpu_stall", cpu_stall, 0);
        check("lock_wr_data", cpu_rdata, 32'd3);
        // Reset on the 5th locked read beat
        tick();
        idle(); ld_req = 1; ld_lock = 1; ld_addr = 32'h10;
        for (int b = 1; b <= 4; b++) begin
            if (b > 1) tick();
            #1;
            check($sformatf("rlock_gnt%0d", b), ld_gnt, 1);
        end
        tick();
        rst = 0; cpu_re = 1;
        #1;
        check("rlock_rst_gnt", ld_gnt, 0);
        check("rlock_rst_stall", cpu_stall, 0);
        check("rlock_rst_re", mem_re, 0);
        tick();
        #1;
        check("rlock_rvalid", ld_rvalid, 0);
        check("rlock_gnt_after", ld_gnt, 0);
        tick();
        rst = 1; cpu_addr = 32'h40;
        #1;
        check("post_rst_stall", cpu_stall, 0);
        check("post_rst_gnt", ld_gnt, 0);
        check("post_rst_re", mem_re, 1);
        check("post_rst_data", cpu_rdata, 32'hDEADBEEF);
        tick();
        idle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
